// File: rtl/mem_stage.sv
// LA32R memory-access pipeline stage: waits for the data-SRAM response, extends
// load data, forwards results to decode and drops a stale response after a flush.
module mem_stage (
    input  logic        clk,
    input  logic        resetn,

    input  logic        ws_allowin,
    output logic        ms_allowin,

    input  logic        es_to_ms_valid,
    input  logic [31:0] es_pc,
    input  logic [31:0] es_result,
    input  logic [4:0]  es_dest,
    input  logic        es_gr_we,
    input  logic        es_res_from_mem,
    input  logic        es_mem_req,
    input  logic [4:0]  es_load_op,
    input  logic        es_ex,

    input  logic        ms_flush_pipe,

    input  logic        data_sram_data_ok,
    input  logic [31:0] data_sram_rdata,

    output logic        ms_to_ws_valid,
    output logic [31:0] ms_pc,
    output logic [31:0] ms_final_result,
    output logic [4:0]  ms_dest,
    output logic        ms_gr_we,
    output logic        ms_ex,

    output logic        ms_fwd_valid,
    output logic        ms_blk_valid,
    output logic [4:0]  ms_fwd_dest,
    output logic [31:0] ms_fwd_result
);

    // Handshake: a transfer happens on a cycle where valid && allowin are both
    // high at the clock edge; a producer holds its payload until that cycle.

    logic        ms_valid_q, ms_valid_d;
    logic [31:0] pc_q;
    logic [31:0] result_q;
    logic [4:0]  dest_q;
    logic        gr_we_q;
    logic        res_from_mem_q;
    logic        mem_req_q;
    logic [4:0]  load_op_q;
    logic        ex_q;

    logic [31:0] data_buf_q, data_buf_d;
    logic        data_buf_valid_q, data_buf_valid_d;
    logic        discard_q, discard_d;

    logic        ms_ready_go;
    logic        in_fire;
    logic        out_fire;
    logic        buf_capture;
    logic        discard_set;

    logic [31:0] load_word;
    logic [7:0]  load_byte;
    logic [15:0] load_half;
    logic [31:0] load_value;

    assign ms_ready_go    = !mem_req_q || ex_q || data_buf_valid_q || data_sram_data_ok;
    assign ms_allowin     = !discard_q && (!ms_valid_q || (ms_ready_go && ws_allowin));
    assign ms_to_ws_valid = ms_valid_q && ms_ready_go && !ms_flush_pipe;

    assign in_fire  = es_to_ms_valid && ms_allowin;
    assign out_fire = ms_to_ws_valid && ws_allowin;

    // A response that arrives while write-back is stalled must be held, because
    // the SRAM presents rdata for a single cycle only.
    assign buf_capture = ms_valid_q && mem_req_q && !discard_q
                         && data_sram_data_ok && !ws_allowin;

    // A flushed request still in flight leaves one response owed to nobody.
    assign discard_set = ms_flush_pipe && ms_valid_q && mem_req_q && !ex_q
                         && !data_buf_valid_q && !data_sram_data_ok;

    always_comb begin
        ms_valid_d       = ms_valid_q;
        data_buf_d       = data_buf_q;
        data_buf_valid_d = data_buf_valid_q;
        discard_d        = discard_q;

        if (ms_flush_pipe) begin
            ms_valid_d = 1'b0;
        end else if (ms_allowin) begin
            ms_valid_d = es_to_ms_valid;
        end

        if (ms_flush_pipe || out_fire) begin
            data_buf_valid_d = 1'b0;
        end else if (buf_capture) begin
            data_buf_valid_d = 1'b1;
            data_buf_d       = data_sram_rdata;
        end

        if (discard_q && data_sram_data_ok) begin
            discard_d = 1'b0;
        end else if (discard_set) begin
            discard_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ms_valid_q       <= 1'b0;
            data_buf_q       <= 32'h0;
            data_buf_valid_q <= 1'b0;
            discard_q        <= 1'b0;
        end else begin
            ms_valid_q       <= ms_valid_d;
            data_buf_q       <= data_buf_d;
            data_buf_valid_q <= data_buf_valid_d;
            discard_q        <= discard_d;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pc_q           <= 32'h0;
            result_q       <= 32'h0;
            dest_q         <= 5'h0;
            gr_we_q        <= 1'b0;
            res_from_mem_q <= 1'b0;
            mem_req_q      <= 1'b0;
            load_op_q      <= 5'h0;
            ex_q           <= 1'b0;
        end else if (in_fire) begin
            pc_q           <= es_pc;
            result_q       <= es_result;
            dest_q         <= es_dest;
            gr_we_q        <= es_gr_we;
            res_from_mem_q <= es_res_from_mem;
            mem_req_q      <= es_mem_req;
            load_op_q      <= es_load_op;
            ex_q           <= es_ex;
        end
    end

    assign load_word = data_buf_valid_q ? data_buf_q : data_sram_rdata;
    assign load_half = result_q[1] ? load_word[31:16] : load_word[15:0];

    always_comb begin
        load_byte = load_word[7:0];
        case (result_q[1:0])
            2'd0: load_byte = load_word[7:0];
            2'd1: load_byte = load_word[15:8];
            2'd2: load_byte = load_word[23:16];
            2'd3: load_byte = load_word[31:24];
            default: load_byte = load_word[7:0];
        endcase
    end

    // load_op is one-hot; ld.w and any unexpected code take the whole word.
    always_comb begin
        load_value = load_word;
        if (load_op_q[0]) begin
            load_value = {{24{load_byte[7]}}, load_byte};
        end else if (load_op_q[1]) begin
            load_value = {{16{load_half[15]}}, load_half};
        end else if (load_op_q[3]) begin
            load_value = {24'h0, load_byte};
        end else if (load_op_q[4]) begin
            load_value = {16'h0, load_half};
        end
    end

    assign ms_final_result = res_from_mem_q ? load_value : result_q;
    assign ms_pc           = pc_q;
    assign ms_dest         = dest_q;
    assign ms_ex           = ms_valid_q && ex_q;
    assign ms_gr_we        = gr_we_q && !ms_ex;

    assign ms_fwd_valid  = ms_to_ws_valid && ms_gr_we;
    assign ms_blk_valid  = ms_valid_q && res_from_mem_q && !ms_ready_go;
    assign ms_fwd_dest   = dest_q;
    assign ms_fwd_result = ms_final_result;

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed scenarios with literal expectations, then random
// traffic checked every cycle against a transaction-level model of the stage.
module tb_mem_stage;

    logic        clk;
    logic        resetn;
    logic        ws_allowin;
    logic        ms_allowin;
    logic        es_to_ms_valid;
    logic [31:0] es_pc;
    logic [31:0] es_result;
    logic [4:0]  es_dest;
    logic        es_gr_we;
    logic        es_res_from_mem;
    logic        es_mem_req;
    logic [4:0]  es_load_op;
    logic        es_ex;
    logic        ms_flush_pipe;
    logic        data_sram_data_ok;
    logic [31:0] data_sram_rdata;
    logic        ms_to_ws_valid;
    logic [31:0] ms_pc;
    logic [31:0] ms_final_result;
    logic [4:0]  ms_dest;
    logic        ms_gr_we;
    logic        ms_ex;
    logic        ms_fwd_valid;
    logic        ms_blk_valid;
    logic [4:0]  ms_fwd_dest;
    logic [31:0] ms_fwd_result;

    int n_checks = 0;
    int n_errors = 0;

    mem_stage dut (
        .clk               (clk),
        .resetn            (resetn),
        .ws_allowin        (ws_allowin),
        .ms_allowin        (ms_allowin),
        .es_to_ms_valid    (es_to_ms_valid),
        .es_pc             (es_pc),
        .es_result         (es_result),
        .es_dest           (es_dest),
        .es_gr_we          (es_gr_we),
        .es_res_from_mem   (es_res_from_mem),
        .es_mem_req        (es_mem_req),
        .es_load_op        (es_load_op),
        .es_ex             (es_ex),
        .ms_flush_pipe     (ms_flush_pipe),
        .data_sram_data_ok (data_sram_data_ok),
        .data_sram_rdata   (data_sram_rdata),
        .ms_to_ws_valid    (ms_to_ws_valid),
        .ms_pc             (ms_pc),
        .ms_final_result   (ms_final_result),
        .ms_dest           (ms_dest),
        .ms_gr_we          (ms_gr_we),
        .ms_ex             (ms_ex),
        .ms_fwd_valid      (ms_fwd_valid),
        .ms_blk_valid      (ms_blk_valid),
        .ms_fwd_dest       (ms_fwd_dest),
        .ms_fwd_result     (ms_fwd_result)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- checking helpers ----------------
    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Load data as the architecture defines it, from address offset and word.
    function automatic logic [31:0] load_value(input logic [4:0] op, input logic [31:0] addr,
                                               input logic [31:0] w);
        int unsigned a;
        logic [31:0] b;
        logic [31:0] h;
        a = addr & 32'd3;
        b = (w >> (8 * a)) & 32'hFF;
        h = (a >= 2) ? (w >> 16) : (w & 32'hFFFF);
        case (op)
            5'b00001: return (b >= 32'd128) ? b + 32'hFFFF_FF00 : b;
            5'b00010: return (h >= 32'd32768) ? h + 32'hFFFF_0000 : h;
            5'b01000: return b;
            5'b10000: return h;
            default:  return w;
        endcase
    endfunction

    // ---------------- behavioural model ----------------
    // The stage holds at most one instruction (m_occ); m_* fields are those of the
    // last instruction accepted. m_have_data means its response already arrived;
    // m_drop means a flushed request still owes a response that must be ignored.
    bit          m_occ = 0;
    bit          m_have_data = 0;
    bit          m_drop = 0;
    logic [31:0] m_data = 0;
    logic [31:0] m_pc = 0;
    logic [31:0] m_result = 0;
    logic [4:0]  m_dest = 0;
    logic        m_gr_we = 0;
    logic        m_rfm = 0;
    logic        m_req = 0;
    logic [4:0]  m_op = 0;
    logic        m_ex = 0;

    function automatic bit m_result_ready();
        // Result exists unless an outstanding, non-faulting access has no data yet.
        return !(m_req && !m_ex && !m_have_data && !data_sram_data_ok);
    endfunction

    function automatic bit m_exp_leave_valid();
        return m_occ && m_result_ready() && !ms_flush_pipe;
    endfunction

    function automatic bit m_exp_accept();
        if (m_drop) return 0;
        if (!m_occ) return 1;
        return m_result_ready() && ws_allowin;
    endfunction

    initial begin : model_proc
        bit rdy, leave, acc, had;
        forever begin
            @(posedge clk or negedge resetn);
            if (!resetn) begin
                m_occ = 0; m_have_data = 0; m_drop = 0; m_data = 0;
                m_pc = 0; m_result = 0; m_dest = 0; m_gr_we = 0;
                m_rfm = 0; m_req = 0; m_op = 0; m_ex = 0;
            end else begin
                rdy   = m_result_ready();
                leave = m_exp_leave_valid() && ws_allowin;
                acc   = m_exp_accept();
                had   = m_have_data;
                if (m_drop && data_sram_data_ok) begin
                    m_drop = 0;
                end else if (m_occ && m_req && !m_ex && !m_have_data && data_sram_data_ok) begin
                    m_have_data = 1;
                    m_data = data_sram_rdata;
                end
                if (ms_flush_pipe) begin
                    if (m_occ && m_req && !m_ex && !had && !data_sram_data_ok) m_drop = 1;
                    m_occ = 0;
                    m_have_data = 0;
                end else if (leave) begin
                    m_occ = 0;
                    m_have_data = 0;
                end
                if (es_to_ms_valid && acc) begin
                    m_pc = es_pc; m_result = es_result; m_dest = es_dest;
                    m_gr_we = es_gr_we; m_rfm = es_res_from_mem; m_req = es_mem_req;
                    m_op = es_load_op; m_ex = es_ex;
                    if (!ms_flush_pipe) begin
                        m_occ = 1;
                        m_have_data = 0;
                    end
                end
                if (rdy && 1'b0) m_occ = 0;
            end
        end
    end

    // ---------------- compare process (opposite edge) ----------------
    initial begin : compare_proc
        bit          e_leave, e_ex, e_gr_we;
        logic [31:0] e_final;
        forever begin
            @(negedge clk);
            e_leave = m_exp_leave_valid();
            e_ex    = m_occ && m_ex;
            e_gr_we = m_gr_we && !e_ex;
            e_final = m_rfm ? load_value(m_op, m_result, m_have_data ? m_data : data_sram_rdata)
                            : m_result;
            check1("ms_to_ws_valid", ms_to_ws_valid, e_leave);
            check1("ms_allowin", ms_allowin, m_exp_accept());
            check1("ms_ex", ms_ex, e_ex);
            check1("ms_gr_we", ms_gr_we, e_gr_we);
            check1("ms_fwd_valid", ms_fwd_valid, e_leave && e_gr_we);
            check1("ms_blk_valid", ms_blk_valid, m_occ && m_rfm && !m_result_ready());
            check32("ms_pc", ms_pc, m_pc);
            check32("ms_dest", {27'h0, ms_dest}, {27'h0, m_dest});
            if (e_leave) begin
                check32("ms_final_result", ms_final_result, e_final);
                check32("ms_fwd_result", ms_fwd_result, e_final);
                check32("ms_fwd_dest", {27'h0, ms_fwd_dest}, {27'h0, m_dest});
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        es_to_ms_valid    = 1'b0;
        es_pc             = 32'h0;
        es_result         = 32'h0;
        es_dest           = 5'h0;
        es_gr_we          = 1'b0;
        es_res_from_mem   = 1'b0;
        es_mem_req        = 1'b0;
        es_load_op        = 5'h0;
        es_ex             = 1'b0;
        ms_flush_pipe     = 1'b0;
        data_sram_data_ok = 1'b0;
        data_sram_rdata   = 32'h0;
        ws_allowin        = 1'b1;
    endtask

    task automatic send(input logic [31:0] pc, input logic [31:0] res, input logic [4:0] dest,
                        input logic gr_we, input logic rfm, input logic req,
                        input logic [4:0] op, input logic ex);
        es_to_ms_valid  = 1'b1;
        es_pc           = pc;
        es_result       = res;
        es_dest         = dest;
        es_gr_we        = gr_we;
        es_res_from_mem = rfm;
        es_mem_req      = req;
        es_load_op      = op;
        es_ex           = ex;
        next_cycle();
        es_to_ms_valid  = 1'b0;
    endtask

    task automatic load_byte_case(input logic [4:0] op, input logic [31:0] exp);
        send(32'h1c00_0010, 32'h0000_1003, 5'd7, 1'b1, 1'b1, 1'b1, op, 1'b0);
        #1 check1("blk_wait1", ms_blk_valid, 1'b1);
        next_cycle();
        #1 check1("blk_wait2", ms_blk_valid, 1'b1);
        next_cycle();
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'h80FF_0000;
        #1;
        check1("ldb_valid", ms_to_ws_valid, 1'b1);
        check1("ldb_blk_off", ms_blk_valid, 1'b0);
        check32("ldb_result", ms_final_result, exp);
        next_cycle();
        data_sram_data_ok = 1'b0;
    endtask

    // ---------------- random stimulus state ----------------
    bit          mem_pending = 0;
    int unsigned mem_delay = 0;
    bit          accepted = 1;

    task automatic random_instr();
        int unsigned kind;
        kind            = $urandom_range(0, 2);
        es_pc           = $urandom & 32'hFFFF_FFFC;
        es_result       = $urandom;
        es_dest         = 5'($urandom_range(0, 31));
        es_ex           = ($urandom_range(0, 9) == 0);
        es_load_op      = 5'h0;
        es_res_from_mem = 1'b0;
        es_mem_req      = 1'b0;
        es_gr_we        = 1'($urandom_range(0, 1));
        if (kind == 1) begin
            es_res_from_mem = 1'b1;
            es_mem_req      = 1'b1;
            es_gr_we        = 1'b1;
            es_load_op      = 5'(1 << $urandom_range(0, 4));
        end else if (kind == 2) begin
            es_mem_req = 1'b1;
            es_gr_we   = 1'b0;
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        resetn = 1'b0;
        idle_inputs();
        repeat (3) @(posedge clk);
        #1;
        check1("rst_allowin", ms_allowin, 1'b1);
        check1("rst_to_ws", ms_to_ws_valid, 1'b0);
        check1("rst_ex", ms_ex, 1'b0);
        check1("rst_fwd", ms_fwd_valid, 1'b0);
        check1("rst_blk", ms_blk_valid, 1'b0);
        check32("rst_result", ms_final_result, 32'h0);
        resetn = 1'b1;
        next_cycle();

        // ALU passthrough and forwarding
        send(32'h1c00_0000, 32'h1234_5678, 5'd5, 1'b1, 1'b0, 1'b0, 5'h0, 1'b0);
        #1;
        check1("alu_valid", ms_to_ws_valid, 1'b1);
        check32("alu_result", ms_final_result, 32'h1234_5678);
        check1("alu_fwd_valid", ms_fwd_valid, 1'b1);
        check32("alu_fwd_dest", {27'h0, ms_fwd_dest}, 32'd5);
        next_cycle();

        // byte loads at offset 3, response two cycles after entry
        load_byte_case(5'b00001, 32'hFFFF_FF80);
        load_byte_case(5'b01000, 32'h0000_0080);

        // ld.hu with write-back stalled: response is buffered
        send(32'h1c00_0020, 32'h0000_1002, 5'd8, 1'b1, 1'b1, 1'b1, 5'b10000, 1'b0);
        ws_allowin        = 1'b0;
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'hBEEF_1234;
        #1;
        check1("buf_ready", ms_to_ws_valid, 1'b1);
        check1("buf_allowin0", ms_allowin, 1'b0);
        next_cycle();
        data_sram_data_ok = 1'b0;
        data_sram_rdata   = 32'h5A5A_A5A5;
        for (int i = 0; i < 2; i++) begin
            #1;
            check1("buf_hold_valid", ms_to_ws_valid, 1'b1);
            check1("buf_hold_allowin", ms_allowin, 1'b0);
            check32("buf_hold_result", ms_final_result, 32'h0000_BEEF);
            next_cycle();
        end
        ws_allowin = 1'b1;
        #1;
        check32("buf_release_result", ms_final_result, 32'h0000_BEEF);
        check1("buf_release_allowin", ms_allowin, 1'b1);
        next_cycle();

        // flush with a load outstanding: the late response is dropped
        send(32'h1c00_0030, 32'h0000_2000, 5'd9, 1'b1, 1'b1, 1'b1, 5'b00100, 1'b0);
        ms_flush_pipe = 1'b1;
        #1 check1("fl_to_ws", ms_to_ws_valid, 1'b0);
        next_cycle();
        ms_flush_pipe = 1'b0;
        #1;
        check1("fl_allowin0", ms_allowin, 1'b0);
        check1("fl_blk0", ms_blk_valid, 1'b0);
        next_cycle();
        #1 check1("fl_still_blocked", ms_allowin, 1'b0);
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'hDEAD_BEEF;
        #1;
        check1("fl_drop_valid", ms_to_ws_valid, 1'b0);
        check1("fl_drop_allowin", ms_allowin, 1'b0);
        next_cycle();
        data_sram_data_ok = 1'b0;
        #1;
        check1("fl_allowin_back", ms_allowin, 1'b1);
        check1("fl_after_valid", ms_to_ws_valid, 1'b0);

        // flush coinciding with the response: nothing is owed afterwards
        send(32'h1c00_0040, 32'h0000_2004, 5'd10, 1'b1, 1'b1, 1'b1, 5'b00100, 1'b0);
        ms_flush_pipe     = 1'b1;
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'h0BAD_F00D;
        #1 check1("flok_to_ws", ms_to_ws_valid, 1'b0);
        next_cycle();
        ms_flush_pipe     = 1'b0;
        data_sram_data_ok = 1'b0;
        #1 check1("flok_allowin", ms_allowin, 1'b1);

        // faulting load does not wait for memory and writes nothing
        send(32'h1c00_0050, 32'h0000_3001, 5'd11, 1'b1, 1'b1, 1'b1, 5'b00100, 1'b1);
        #1;
        check1("ex_valid", ms_to_ws_valid, 1'b1);
        check1("ex_flag", ms_ex, 1'b1);
        check1("ex_gr_we", ms_gr_we, 1'b0);
        check1("ex_fwd", ms_fwd_valid, 1'b0);
        check1("ex_blk", ms_blk_valid, 1'b0);
        next_cycle();

        // asynchronous reset while a load waits
        send(32'h1c00_0100, 32'h0000_3000, 5'd3, 1'b1, 1'b1, 1'b1, 5'b00100, 1'b0);
        #1 check1("ar_blk_before", ms_blk_valid, 1'b1);
        #1 resetn = 1'b0;
        #1;
        check1("ar_allowin", ms_allowin, 1'b1);
        check1("ar_to_ws", ms_to_ws_valid, 1'b0);
        check1("ar_blk", ms_blk_valid, 1'b0);
        check32("ar_pc", ms_pc, 32'h0);
        check32("ar_dest", {27'h0, ms_dest}, 32'h0);
        check32("ar_result", ms_final_result, 32'h0);
        next_cycle();
        resetn            = 1'b1;
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'hCAFE_F00D;
        #1;
        check1("ar_stale_valid", ms_to_ws_valid, 1'b0);
        check1("ar_stale_allowin", ms_allowin, 1'b1);
        next_cycle();
        idle_inputs();

        // randomized traffic with a single-outstanding data SRAM
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (mem_pending) begin
                if (mem_delay == 0) begin
                    data_sram_data_ok = 1'b1;
                    mem_pending = 0;
                end else begin
                    data_sram_data_ok = 1'b0;
                    mem_delay--;
                end
            end else begin
                data_sram_data_ok = 1'b0;
            end
            data_sram_rdata = $urandom;
            ws_allowin      = ($urandom_range(0, 3) != 0);
            ms_flush_pipe   = ($urandom_range(0, 19) == 0);
            if (ms_flush_pipe) begin
                es_to_ms_valid = 1'b0;
                random_instr();
            end else if (accepted || !es_to_ms_valid) begin
                es_to_ms_valid = ($urandom_range(0, 3) != 0);
                random_instr();
            end
            @(negedge clk);
            accepted = es_to_ms_valid && ms_allowin;
            if (accepted && es_mem_req && !es_ex) begin
                mem_pending = 1;
                mem_delay   = $urandom_range(0, 3);
            end
            next_cycle();
        end

        idle_inputs();
        repeat (6) next_cycle();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access pipeline stage between the execute stage and the write-back stage of the LoongArch five-stage pipeline.
- Accepts one instruction per handshake from execute and, for loads and stores, waits for the data-SRAM data_ok response.
- Extracts and sign/zero-extends load data, then hands the final result to write-back.
- Provides a forwarding/blocking port to decode, and discards a stale data response after a pipeline flush.

Parameters:
None (all widths fixed by the LA32R datapath).

Ports:
clk  in  1  pipeline clock
resetn  in  1  asynchronous active-low reset
ws_allowin  in  1  write-back stage can accept
ms_allowin  out  1  this stage can accept from execute
es_to_ms_valid  in  1  execute presents a valid instruction
es_pc  in  32  instruction PC
es_result  in  32  ALU/mul/div result; equals the memory address for load/store
es_dest  in  5  destination GPR
es_gr_we  in  1  GPR write enable
es_res_from_mem  in  1  instruction is a load
es_mem_req  in  1  a data-SRAM request was issued (load or store)
es_load_op  in  5  one-hot: [0]ld.b [1]ld.h [2]ld.w [3]ld.bu [4]ld.hu
es_ex  in  1  instruction carries an exception
ms_flush_pipe  in  1  flush (exception/ertn taken in write-back)
data_sram_data_ok  in  1  data response valid
data_sram_rdata  in  32  load data
ms_to_ws_valid  out  1  valid instruction to write-back
ms_pc  out  32  registered PC
ms_final_result  out  32  load-extended data or passthrough es_result
ms_dest  out  5  registered destination
ms_gr_we  out  1  registered GPR write enable; forced 0 when ms_ex
ms_ex  out  1  ms_valid && registered es_ex; also feeds execute store suppression
ms_fwd_valid  out  1  ms_to_ws_valid && ms_gr_we
ms_blk_valid  out  1  ms_valid && load && !ms_ready_go (result not yet available)
ms_fwd_dest  out  5  equals ms_dest
ms_fwd_result  out  32  equals ms_final_result

Behaviour:
- Reset (resetn=0, asynchronous): ms_valid=0, data_buf_valid=0, discard=0, all bus registers=0.
  - Resulting outputs: ms_allowin=1, ms_to_ws_valid=0, ms_ex=0, ms_fwd_valid=0, ms_blk_valid=0; data outputs 0.
- Pipeline registers:
  - ms_valid loads es_to_ms_valid when ms_allowin, except a flush clears it (flush wins).
  - Field registers capture on es_to_ms_valid && ms_allowin.
- ms_allowin = !discard && (!ms_valid || (ms_ready_go && ws_allowin)).
- ms_ready_go = !mem_req_r || ms_ex_r || data_buf_valid || data_sram_data_ok.
- ms_to_ws_valid = ms_valid && ms_ready_go && !ms_flush_pipe.
- Data buffer:
  - Capture data_sram_rdata into data_buf and set data_buf_valid when ms_valid && mem_req_r && !discard && data_sram_data_ok && !ws_allowin.
  - Clear data_buf_valid on the handshake to write-back or on flush.
  - Load data source = data_buf_valid ? data_buf : data_sram_rdata.
- Load extension, with a = result_r[1:0]:
  - Byte = data >> (8*a) [7:0]; half = a[1] ? data[31:16] : data[15:0].
  - ld.b/ld.h sign-extend; ld.bu/ld.hu zero-extend; ld.w takes the full word.
  - ms_final_result = res_from_mem_r ? extended load data : result_r.
- Store: waits for data_ok only; the result passes through unchanged and gr_we is already 0.
- Discard (at most one outstanding request):
  - On ms_flush_pipe with ms_valid && mem_req_r && !ms_ex_r && !data_buf_valid and no data_ok in the same cycle, set discard.
  - The next data_ok clears discard and its data is dropped. ms_allowin stays 0 while discard=1.
  - Flush with data_ok in the same cycle: no discard is set.
- Latency: non-memory instruction is 1 cycle. Load result is valid in the data_ok cycle (0 extra cycles if data_ok arrives in the first ms cycle).
- Reset mid-transaction: all state cleared immediately; any later data_ok with discard=0 and ms_valid=0 is ignored.

Test Plan:
- ALU op, es_result=0x1234_5678, gr_we=1, dest=5, ws_allowin=1 -> next cycle ms_to_ws_valid=1, ms_final_result=0x1234_5678, ms_fwd_valid=1, ms_fwd_dest=5.
- ld.b at addr 0x..03, rdata=0x80FF_0000, data_ok 2 cycles after entry -> ms_blk_valid=1 for 2 cycles, then ms_final_result=0xFFFF_FF80. Repeat with ld.bu -> 0x0000_0080.
- ld.hu at addr 0x..02, rdata=0xBEEF_1234, data_ok while ws_allowin=0 for 3 cycles -> result buffered, ms_ready_go stays 1. When ws_allowin=1 -> ms_final_result=0x0000_BEEF, ms_allowin=1.
- Load pending, ms_flush_pipe pulse before data_ok -> ms_valid=0, ms_allowin=0. The next data_ok (rdata=0xDEAD_BEEF) is dropped, ms_to_ws_valid stays 0, ms_allowin returns to 1 the cycle after.
- es_ex=1 on a load with mem_req=1 -> ready_go=1 without data_ok, ms_ex=1, ms_gr_we=0, ms_fwd_valid=0.
- Assert resetn=0 mid-load -> all outputs return to reset values asynchronously, before the next clk edge.
